step_sequencer: RTL
===================

// Module: step_sequencer
// PURPOSE
// Initiator side of the quarter-step timing handshake. Accepts a move command (step count, direction, full/half mode).
// For each step it fires start_count to the quarter-step counter, waits for end_count, then advances the coil phase.
// Sits between the motor command logic and the coil drivers; owns coil phase, position and remaining-step state.
// PARAMETERS
// STEP_W  16  width of steps / steps_left (max move = 2**STEP_W-1 steps)
// POS_W   24  width of signed absolute position counter
// PORTS
// clk         in   1       system clock
// reset       in   1       synchronous, active-high reset
// go          in   1       move request, sampled only in IDLE
// steps       in   STEP_W  number of steps for the move, captured with go
// dir         in   1       1 = forward (phase index +), 0 = reverse; captured with go
// half_mode   in   1       1 = half-step table walk, 0 = full (two-coil) stepping; captured with go
// stop        in   1       abort request: finish the step in flight, then end the move
// end_count   in   1       level from the quarter-step counter; high = dwell complete
// start_count out  1       registered; high exactly one cycle per step (rising edge starts the counter)
// coils       out  4       registered {A,B,A_n,B_n} coil drive
// busy        out  1       high from the cycle after go is accepted until DONE is left
// done        out  1       one-cycle pulse at move end (normal or stopped)
// steps_left  out  STEP_W  remaining steps
// position    out  POS_W   signed step position, two's complement
// BEHAVIOUR
// Reset: state=IDLE; start_count=0; coils=4'b0000; busy=0; done=0; steps_left=0; position=0; phase idx=0; energized=0.
// States: IDLE, WAIT_CLR, ARM, WAIT_END, ADVANCE, DONE.
// IDLE: go=1 and stop=0 -> capture steps/dir/half_mode and set energized (coils=table[idx]).
//   steps!=0 -> WAIT_CLR; steps==0 -> DONE. go with stop=1 ignored. go outside IDLE ignored.
// WAIT_CLR: wait for end_count==0 (stale end_count from a prior dwell or a reset mismatch).
//   stop_pend -> DONE; else end_count==0 -> ARM.
// ARM: start_count=1 for this single cycle -> WAIT_END. start_count is low >=3 cycles between pulses.
// WAIT_END: end_count==1 -> ADVANCE; no timeout.
// ADVANCE (1 cycle): update idx; coils<=table[new idx]; position+=dir?1:-1 (wraps); steps_left-=1.
//   -> DONE if new steps_left==0 or stop_pend; else -> WAIT_CLR.
// DONE: done=1 for one cycle; clear stop_pend -> IDLE.
// stop: sticky stop_pend set whenever busy and stop=1.
//   Seen in WAIT_CLR: move ends with no further step. Seen in ARM/WAIT_END: step completes first.
// Phase table idx 0..7: 1000,1100,0100,0110,0010,0011,0001,1001. idx arithmetic is mod 8.
// half_mode=1: idx+=dir?1:-1.
// half_mode=0: idx odd -> idx+=dir?2:-2; idx even -> idx+=dir?1:-1 (alignment step, counted as a step).
// Latency: go accepted at edge N; if end_count=0, start_count high in cycle N+1.
//   ADVANCE follows the first cycle end_count is seen high; coils update 1 cycle later.
// Coils hold last pattern in IDLE after a move (holding torque). Only reset de-energizes.
// reset mid-move: everything returns to reset values that cycle; any start_count pulse is truncated.
// STRUCTURE
// Shared package step_motor_pkg: state encoding, COIL_OFF constant, 8-entry phase table constant.
// Sub-module step_phase_lut: combinational idx[2:0] -> coils[3:0], reused by future coil-driver blocks.
// TESTING
// Bench pairs the DUT with the quarter-step counter: TIME_TO_COUNT=4, enable tied high. Checks include a start_count-spacing monitor.
// 1. reset, go steps=3 dir=1 half=1 -> 3 start_count pulses; coils 1100,0100,0110; position=3; done once; busy low after.
// 2. from idx=0, go steps=2 dir=1 half=0 -> idx 1 then 3, coils 1100,0110; position=2.
// 3. from idx=0, go steps=1 dir=0 half=1 -> idx wraps to 7, coils=1001, position=-1 (all ones).
// 4. go steps=5, stop asserted during 2nd WAIT_END -> exactly 2 advances, steps_left=3, done pulse, no 3rd start_count.
// 5. go steps=0 -> no start_count, done pulses 1 cycle after acceptance; coils energized to table[idx].
// 6. end_count forced high at go -> DUT holds WAIT_CLR with no start_count until end_count falls.
//    Also: go while busy ignored; reset in WAIT_END returns all outputs to reset values next cycle.

Source files
------------

// File: rtl/step_motor_pkg.sv
// rtl/step_motor_pkg.sv - shared stepper types: sequencer states, coil-off pattern, half-step phase table.
package step_motor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_CLR,
      ST_ARM,
      ST_WAIT_END,
      ST_ADVANCE,
      ST_DONE
   } state_e;

   localparam logic [3:0] COIL_OFF = 4'b0000;

   // Element i is the {A,B,A_n,B_n} drive for phase index i; odd entries energize two coils.
   localparam logic [7:0][3:0] PHASE_TABLE = {
      4'b1001, 4'b0001, 4'b0011, 4'b0010,
      4'b0110, 4'b0100, 4'b1100, 4'b1000
   };

endpackage

// File: rtl/step_sequencer_if.sv
// rtl/step_sequencer_if.sv - move command / status bundle between motor command logic and the sequencer.
interface step_sequencer_if #(
   parameter int STEP_W = 16,
   parameter int POS_W  = 24
);
   logic              go;
   logic [STEP_W-1:0] steps;
   logic              dir;
   logic              half_mode;
   logic              stop;
   logic              busy;
   logic              done;
   logic [STEP_W-1:0] steps_left;
   logic [POS_W-1:0]  position;

   modport master (
      output go, steps, dir, half_mode, stop,
      input  busy, done, steps_left, position
   );

   modport slave (
      input  go, steps, dir, half_mode, stop,
      output busy, done, steps_left, position
   );
endinterface

// File: rtl/step_phase_lut.sv
// rtl/step_phase_lut.sv - combinational phase index to coil pattern lookup.
module step_phase_lut
   import step_motor_pkg::*;
(
   input  logic [2:0] idx,
   output logic [3:0] coils
);
   always_comb begin
      coils = PHASE_TABLE[idx];
   end
endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - move sequencer: one start_count/end_count dwell per step, then advance coil phase.
module step_sequencer
   import step_motor_pkg::*;
#(
   parameter int STEP_W = 16,
   parameter int POS_W  = 24
)(
   input  logic             clk,
   input  logic             reset,
   step_sequencer_if.slave  cmd,
   output logic             start_count,
   input  logic             end_count,
   output logic [3:0]       coils
);
   state_e            state_q, state_d;
   logic [2:0]        idx_q, idx_d, lut_idx;
   logic [3:0]        coils_q, coils_d, lut_coils;
   logic [STEP_W-1:0] steps_left_q, steps_left_d;
   logic [POS_W-1:0]  position_q, position_d;
   logic              dir_q, dir_d, half_q, half_d;
   logic              stop_pend_q, stop_pend_d;
   logic              start_q, start_d, busy_q, busy_d, done_q, done_d;
   logic              stop_now;

   // Full stepping moves two table slots from an odd index; from an even index it first aligns by one.
   always_comb begin
      lut_idx = idx_q;
      if (state_q == ST_ADVANCE) begin
         if (half_q || !idx_q[0]) lut_idx = dir_q ? idx_q + 3'd1 : idx_q - 3'd1;
         else                     lut_idx = dir_q ? idx_q + 3'd2 : idx_q - 3'd2;
      end
   end

   step_phase_lut u_lut (
      .idx   (lut_idx),
      .coils (lut_coils)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      coils_d      = coils_q;
      steps_left_d = steps_left_q;
      position_d   = position_q;
      dir_d        = dir_q;
      half_d       = half_q;
      stop_now     = stop_pend_q | (busy_q & cmd.stop);
      stop_pend_d  = stop_now;

      case (state_q)
         ST_IDLE: begin
            if (cmd.go && !cmd.stop) begin
               dir_d        = cmd.dir;
               half_d       = cmd.half_mode;
               steps_left_d = cmd.steps;
               coils_d      = lut_coils;
               state_d      = (cmd.steps == '0) ? ST_DONE : ST_WAIT_CLR;
            end
         end
         ST_WAIT_CLR: begin
            if (stop_now)        state_d = ST_DONE;
            else if (!end_count) state_d = ST_ARM;
         end
         ST_ARM: state_d = ST_WAIT_END;
         ST_WAIT_END: begin
            if (end_count) state_d = ST_ADVANCE;
         end
         ST_ADVANCE: begin
            idx_d        = lut_idx;
            coils_d      = lut_coils;
            position_d   = dir_q ? position_q + POS_W'(1) : position_q - POS_W'(1);
            steps_left_d = steps_left_q - STEP_W'(1);
            state_d      = (steps_left_d == '0 || stop_now) ? ST_DONE : ST_WAIT_CLR;
         end
         ST_DONE: begin
            stop_pend_d = 1'b0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      start_d = (state_d == ST_ARM);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= 3'd0;
         coils_q      <= COIL_OFF;
         steps_left_q <= '0;
         position_q   <= '0;
         dir_q        <= 1'b0;
         half_q       <= 1'b0;
         stop_pend_q  <= 1'b0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         coils_q      <= coils_d;
         steps_left_q <= steps_left_d;
         position_q   <= position_d;
         dir_q        <= dir_d;
         half_q       <= half_d;
         stop_pend_q  <= stop_pend_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign start_count    = start_q;
   assign coils          = coils_q;
   assign cmd.busy       = busy_q;
   assign cmd.done       = done_q;
   assign cmd.steps_left = steps_left_q;
   assign cmd.position   = position_q;
endmodule
